// File: rtl/seq_div.sv
// seq_div: sequential signed restoring divider, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high), start, dividend, divisor in;
//        busy, done, quotient, remainder, dz out.
// Optional macro SEQ_DIV_DZ_DETECT_EN enables the divide-by-zero shortcut.
module seq_div #(
    parameter int OPERAND_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPERAND_SIZE-1:0] dividend,
    input  logic [OPERAND_SIZE-1:0] divisor,
    output logic                    busy,
    output logic                    done,
    output logic [OPERAND_SIZE-1:0] quotient,
    output logic [OPERAND_SIZE-1:0] remainder,
    output logic                    dz
);

    localparam int N  = OPERAND_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [N-1:0]  ONE_N    = N'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    // Dividend magnitude shifts out MSB first while quotient bits shift in,
    // so after N steps this register holds |quotient|.
    logic [N-1:0]  qsh;
    logic [N:0]    rem_p;
    logic [N:0]    dmag;
    logic          sign_a;
    logic          sign_b;

    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N:0]    r_shift;
    logic [N:0]    r_sub;
    logic          ge;
    logic [N-1:0]  q_signed;
    logic [N-1:0]  r_signed;

    // N-bit negation of -2^(N-1) yields 2^(N-1) read as unsigned: exact.
    always_comb begin
        a_mag    = dividend[N-1] ? (~dividend + ONE_N) : dividend;
        b_mag    = divisor[N-1] ? (~divisor + ONE_N) : divisor;
        r_shift  = (rem_p << 1) | {{N{1'b0}}, qsh[N-1]};
        ge       = (r_shift >= dmag);
        r_sub    = r_shift - dmag;
        q_signed = (sign_a ^ sign_b) ? (~qsh + ONE_N) : qsh;
        r_signed = sign_a ? (~rem_p[N-1:0] + ONE_N) : rem_p[N-1:0];
    end

    assign busy = (state == S_CALC) || (state == S_SIGN);
    assign done = (state == S_DONE);

`ifdef SEQ_DIV_DZ_DETECT_EN
    logic dz_q;
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            qsh       <= '0;
            rem_p     <= '0;
            dmag      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_DZ_DETECT_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sign_a <= dividend[N-1];
                        sign_b <= divisor[N-1];
                        qsh    <= a_mag;
                        dmag   <= {1'b0, b_mag};
                        rem_p  <= '0;
                        cnt    <= CNT_INIT;
                        state  <= S_CALC;
`ifdef SEQ_DIV_DZ_DETECT_EN
                        if (divisor == '0) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            dz_q      <= 1'b1;
                            state     <= S_DONE;
                        end
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    rem_p <= ge ? r_sub : r_shift;
                    qsh   <= {qsh[N-2:0], ge};
                    if (cnt == '0) begin
                        state <= S_SIGN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SIGN: begin
                    quotient  <= q_signed;
                    remainder <= r_signed;
`ifdef SEQ_DIV_DZ_DETECT_EN
                    dz_q      <= 1'b0;
`endif
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div with a plain-arithmetic model.
// Directed corner cases followed by randomized operand pairs.
module tb_seq_div;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dz;

    seq_div #(.OPERAND_SIZE(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           t0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Truncating division with dividend-signed remainder, straight from ints.
    function automatic exp_t model(input logic [N-1:0] a_v,
                                   input logic [N-1:0] b_v, input int t0);
        int a;
        int b;
        int qi;
        int ri;
        exp_t e;
        a = $signed(a_v);
        b = $signed(b_v);
        e.t0  = t0;
        e.dz  = 1'b0;
        e.lat = N + 2;
        if (b == 0) begin
`ifdef SEQ_DIV_DZ_DETECT_EN
            qi    = 0;
            ri    = a;
            e.dz  = 1'b1;
            e.lat = 1;
`else
            qi = (a < 0) ? -((1 << N) - 1) : ((1 << N) - 1);
            ri = a;
`endif
        end else begin
            qi = a / b;
            ri = a % b;
        end
        e.q = qi[N-1:0];
        e.r = ri[N-1:0];
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("done_busy_exclusive", int'(busy), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("dz", int'(dz), int'(e.dz));
                    chk("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    // Caller is at a negedge with the DUT in IDLE or DONE.
    task automatic issue(input int a, input int b);
        dividend = a[N-1:0];
        divisor  = b[N-1:0];
        start    = 1'b1;
        sb.push_back(model(a[N-1:0], b[N-1:0], cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_q"}, int'(quotient), 0);
        chk({name, "_r"}, int'(remainder), 0);
        chk({name, "_dz"}, int'(dz), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    int dir_a[8] = '{100, 100, -100, -100, -128, -128, 127, 36};
    int dir_b[8] = '{7, -7, 7, -7, -1, 127, -128, 0};

    initial begin
        int n;
        int ra;
        int rb;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Start coincident with reset must be dropped.
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_drops_start_busy", int'(busy), 0);
        chk("rst_drops_start_done", int'(done), 0);

        for (int i = 0; i < 8; i++) begin
            issue(dir_a[i], dir_b[i]);
            wait_idle("drain_directed");
        end

        // Second start during CALC is ignored.
        issue(-72, 5);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle("drain_ignored_start");

        // Reset in the 4th CALC cycle aborts with no done.
        issue(100, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_reset");
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", int'(done), 0);
        issue(3, 4);
        wait_idle("drain_after_reset");

        // Start held high: a second op is accepted from DONE.
        dividend = 8'd20;
        divisor  = 8'd3;
        start    = 1'b1;
        sb.push_back(model(8'd20, 8'd3, cyc));
        @(negedge clk);
        ra = 50;
        rb = -8;
        dividend = ra[N-1:0];
        divisor  = rb[N-1:0];
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("held_start_done_seen", int'(done), 1);
        sb.push_back(model(ra[N-1:0], rb[N-1:0], cyc));
        @(negedge clk);
        start = 1'b0;
        wait_idle("drain_held_start");

        for (int i = 0; i < 150; i++) begin
            ra = $urandom_range(0, 255);
            rb = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 255);
            issue(ra, rb);
            wait_idle("drain_random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle("drain_final");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
